// File: rtl/stream_match_pkg.sv
// Shared types and defaults for the serial key matcher: FSM states, default sizing, reset key table.
// Pure declarations; no latency or backpressure of its own.
package stream_match_pkg;

  localparam int DEF_FRAME_BITS = 128;
  localparam int DEF_NUM_KEYS   = 4;

  typedef enum logic [1:0] {
    ST_RECV   = 2'd0,
    ST_CMP    = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  // Keys are truncated to FRAME_BITS from the LSB end on reset.
  localparam logic [255:0] KEY_DEFAULT [16] = '{
    256'hC0DE0000_00000000_00000000_00000000_FFFFFFFF_00000000_FFFFFFFF_0000005A,
    256'hC0DE0001_00000000_00000000_00000000_01234567_89ABCDEF_FEDCBA98_76543210,
    256'hC0DE0002_00000000_00000000_00000000_DEADBEEF_CAFEF00D_0000FFFF_A5A5A5A5,
    256'hC0DE0003_00000000_00000000_00000000_5A5A5A5A_3C3C3C3C_0F0F0F0F_C3C3C3C3,
    256'hC0DE0004_00000000_00000000_00000000_44444444_44444444_44444444_44444444,
    256'hC0DE0005_00000000_00000000_00000000_55555555_55555555_55555555_55555555,
    256'hC0DE0006_00000000_00000000_00000000_66666666_66666666_66666666_66666666,
    256'hC0DE0007_00000000_00000000_00000000_77777777_77777777_77777777_77777777,
    256'hC0DE0008_00000000_00000000_00000000_88888888_88888888_88888888_88888888,
    256'hC0DE0009_00000000_00000000_00000000_99999999_99999999_99999999_99999999,
    256'hC0DE000A_00000000_00000000_00000000_AAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA,
    256'hC0DE000B_00000000_00000000_00000000_BBBBBBBB_BBBBBBBB_BBBBBBBB_BBBBBBBB,
    256'hC0DE000C_00000000_00000000_00000000_CCCCCCCC_CCCCCCCC_CCCCCCCC_CCCCCCCC,
    256'hC0DE000D_00000000_00000000_00000000_DDDDDDDD_DDDDDDDD_DDDDDDDD_DDDDDDDD,
    256'hC0DE000E_00000000_00000000_00000000_EEEEEEEE_EEEEEEEE_EEEEEEEE_EEEEEEEE,
    256'hC0DE000F_00000000_00000000_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF
  };

endpackage

// File: rtl/key_prio_enc.sv
// Lowest-index priority encoder over the key hit vector; purely combinational.
// No latency, no backpressure; idx is 0 when nothing hits.
module key_prio_enc #(
  parameter int NUM_KEYS = 4,
  localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic [NUM_KEYS-1:0] hit,
  output logic                found,
  output logic [KW-1:0]       idx
);

  always_comb begin
    found = |hit;
    idx   = '0;
    // Scanning downward lets the lowest set bit win.
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (hit[i]) idx = KW'(i);
    end
  end

endmodule

// File: rtl/stream_key_matcher.sv
// Assembles a serial MSB-first frame and compares it against NUM_KEYS stored keys; res_valid 2 cycles after eos.
// bit_ready drops for the CMP and REPORT cycles; bits and eos offered then are ignored.
module stream_key_matcher
  import stream_match_pkg::*;
#(
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int NUM_KEYS   = DEF_NUM_KEYS,
  localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bit_valid,
  input  logic                  bit_in,
  input  logic                  eos,
  output logic                  bit_ready,
  input  logic                  key_we,
  input  logic [KW-1:0]         key_idx,
  input  logic [FRAME_BITS-1:0] key_data,
  output logic [FRAME_BITS-1:0] frame_out,
  output logic                  res_valid,
  output logic                  match,
  output logic [KW-1:0]         match_idx,
  output logic                  len_err
);

  localparam int CW = $clog2(FRAME_BITS + 1) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_OVF  = CW'(FRAME_BITS + 1);
  localparam logic [KW:0]   NK       = (KW + 1)'(NUM_KEYS);

  state_t                state, state_nxt;
  logic [FRAME_BITS-1:0] sr, sr_nxt;
  logic [CW-1:0]         cnt, cnt_nxt, cnt_final;
  logic                  ovf, ovf_nxt;
  logic [FRAME_BITS-1:0] keys [NUM_KEYS];
  logic [NUM_KEYS-1:0]   eq_vec;
  logic                  len_err_q;
  logic                  bit_acc, eos_acc, len_ok;

  assign bit_ready = (state == ST_RECV);
  assign bit_acc   = bit_valid && bit_ready;
  assign eos_acc   = eos && bit_ready;
  assign len_ok    = (cnt_final == CNT_FULL) && !ovf;
  assign res_valid = (state == ST_REPORT);
  assign len_err   = len_err_q;

  // Bits past FRAME_BITS only mark overflow so frame_out keeps the first FRAME_BITS bits.
  always_comb begin
    sr_nxt  = sr;
    cnt_nxt = cnt;
    ovf_nxt = ovf;
    if (bit_acc) begin
      if (cnt < CNT_FULL) begin
        sr_nxt  = {sr[FRAME_BITS-2:0], bit_in};
        cnt_nxt = cnt + CW'(1);
      end else begin
        ovf_nxt = 1'b1;
        cnt_nxt = CNT_OVF;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RECV:   if (eos_acc) state_nxt = ST_CMP;
      ST_CMP:    state_nxt = ST_REPORT;
      ST_REPORT: state_nxt = ST_RECV;
      default:   state_nxt = ST_RECV;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RECV;
      sr        <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      cnt_final <= '0;
      frame_out <= '0;
      eq_vec    <= '0;
      len_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_RECV: begin
          sr  <= sr_nxt;
          cnt <= cnt_nxt;
          ovf <= ovf_nxt;
          if (eos_acc) begin
            frame_out <= sr_nxt;
            cnt_final <= cnt_nxt;
          end
        end
        ST_CMP: begin
          len_err_q <= !len_ok;
          for (int i = 0; i < NUM_KEYS; i++) begin
            eq_vec[i] <= len_ok && (frame_out == keys[i]);
          end
        end
        ST_REPORT: begin
          sr  <= '0;
          cnt <= '0;
          ovf <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // The CMP-cycle compare samples keys before a same-cycle write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        keys[i] <= KEY_DEFAULT[i][FRAME_BITS-1:0];
      end
    end else if (key_we && ({1'b0, key_idx} < NK)) begin
      keys[key_idx] <= key_data;
    end
  end

  key_prio_enc #(
    .NUM_KEYS (NUM_KEYS)
  ) u_prio (
    .hit   (eq_vec),
    .found (match),
    .idx   (match_idx)
  );

endmodule

// File: doc/stream_key_matcher.md
STREAM_KEY_MATCHER -- requirements
Module: stream_key_matcher

Interface
REQ-001 The block SHALL have parameter FRAME_BITS, default 128, giving the frame length in bits (legal range 8..256).
REQ-002 The block SHALL have parameter NUM_KEYS, default 4, giving the number of stored comparison keys (legal range 1..16).
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  is the asynchronous, active-low reset.
REQ-005 Port bit_valid  input  1  qualifies bit_in; a bit is accepted when bit_valid && bit_ready.
REQ-006 Port bit_in  input  1  carries the serial data bit, MSB of the frame first.
REQ-007 Port eos  input  1  is end of sequence; it is accepted when eos && bit_ready.
REQ-008 Port bit_ready  output  1  is high when the block accepts bits and eos.
REQ-009 Port key_we  input  1  is the key write strobe.
REQ-010 Port key_idx  input  $clog2(NUM_KEYS) (min 1)  selects the key slot to write.
REQ-011 Port key_data  input  FRAME_BITS  carries the key write value.
REQ-012 Port frame_out  output  FRAME_BITS  holds the last assembled frame.
REQ-013 Port res_valid  output  1  is a one-cycle pulse qualifying match, match_idx and len_err.
REQ-014 Port match  output  1  is high when the frame equals at least one key.
REQ-015 Port match_idx  output  $clog2(NUM_KEYS) (min 1)  gives the lowest matching key index; it is 0 when match=0.
REQ-016 Port len_err  output  1  is high when the frame bit count was not exactly FRAME_BITS.

Function
REQ-017 The FSM SHALL have three states: RECV, CMP and REPORT; bit_ready=1 only in RECV.
REQ-018 In RECV, an accepted bit SHALL shift into the LSB of the shift register (sr <= {sr[FRAME_BITS-2:0], bit_in}), and the bit counter SHALL increment.
REQ-019 The counter SHALL be $clog2(FRAME_BITS+1)+1 bits wide and saturate at FRAME_BITS+1; once the count equals FRAME_BITS, further bits SHALL NOT shift the register, only set the overflow flag.
REQ-020 When bit_valid and eos are accepted in the same cycle, the bit SHALL be included in the frame before eos is processed.
REQ-021 On accepted eos, the FSM SHALL go RECV->CMP, latch the shift register into frame_out, and latch the final count.
REQ-022 In CMP, the block SHALL register the per-key equality vector frame_out==key[i] for all i; the FSM then goes to CMP->REPORT.
REQ-023 In REPORT, res_valid SHALL be 1 for exactly one cycle, then the FSM goes REPORT->RECV with the counter and overflow flag cleared.
REQ-024 Latency SHALL be fixed: eos accepted in cycle T gives res_valid in cycle T+2; the next bit is accepted no earlier than T+3.
REQ-025 If the final count is not equal to FRAME_BITS (short, zero-length or overflow), then len_err=1, match=0 and match_idx=0.
REQ-026 On multiple key matches, match_idx SHALL be the lowest index.
REQ-027 A key write SHALL take effect on the next clock edge in any state; a write in the RECV cycle that accepts eos is visible to that frame's comparison, and a write during CMP is not.
REQ-028 bit_valid and eos outside RECV SHALL be ignored with no side effects.
REQ-029 match, match_idx and len_err SHALL hold their values until the next REPORT; res_valid is 0 outside REPORT.

Reset
REQ-030 Asserting rst_n low at any time, including mid-frame or in CMP/REPORT, SHALL immediately force:
- state = RECV
- counter = 0, overflow flag = 0
- shift register = 0, frame_out = 0
- res_valid = 0, match = 0, match_idx = 0, len_err = 0
REQ-031 On reset, key[i] SHALL be loaded with the package default constant KEY_DEFAULT[i].
REQ-032 bit_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-033 A shared package stream_match_pkg SHALL hold:
- the state enum type
- the default FRAME_BITS and NUM_KEYS values
- the KEY_DEFAULT constant array (16 entries of 256 bits, truncated to FRAME_BITS)
REQ-034 The lowest-index priority encoder SHALL be a sub-module named key_prio_enc, parameterised by NUM_KEYS.

Verification (FRAME_BITS=128, NUM_KEYS=4, KEY_DEFAULT[1]=128'h0123456789ABCDEFFEDCBA9876543210, KEY_DEFAULT[2]=128'hDEADBEEF_CAFEF00D_0000FFFF_A5A5A5A5)
REQ-035 Serial KEY_DEFAULT[1] MSB-first, last bit sent with eos -> res_valid 2 cycles later; match=1, match_idx=1, len_err=0, frame_out=KEY_DEFAULT[1].
REQ-036 Write key 3 = KEY_DEFAULT[1], then send the same frame -> match=1, match_idx=1 (lowest index wins).
REQ-037 Send 127 bits then eos -> len_err=1, match=0; send 130 bits of KEY_DEFAULT[2] then eos -> len_err=1, match=0, frame_out = first 128 bits.
REQ-038 Send 128'h0 (no default key equals 0) -> match=0, match_idx=0, len_err=0; bit_valid held high during CMP/REPORT leaves the next frame's count unchanged.
REQ-039 Pulse rst_n low after 64 bits, then send KEY_DEFAULT[2] -> match=1, match_idx=2, no residue from the aborted frame.
